bp_cce_mem_arbiter: RTL and testbench

//   Shares one CCE-Mem port between num_cce_p buffered CCEs. Round-robin over mem_cmd requests, one-entry

---
 rtl/bp_cce_mem_arbiter_pkg.sv | 17 +
 rtl/bp_cce_mem_arbiter_if.sv | 39 +++
 rtl/bp_cce_mem_arbiter_credit_counter.sv | 28 ++
 rtl/bp_cce_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bp_cce_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_cce_mem_arbiter_pkg.sv
// rtl/bp_cce_mem_arbiter_pkg.sv - shared types and helpers for the CCE-Mem arbiter
package bp_cce_mem_arbiter_pkg;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Occupancy of the one-entry registered command slot toward memory.
    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    localparam int perf_cnt_width_lp = 32;

endpackage

// File: rtl/bp_cce_mem_arbiter_if.sv
// rtl/bp_cce_mem_arbiter_if.sv - CCE and memory side handshake bundle for the arbiter
interface bp_cce_mem_arbiter_if
    import bp_cce_mem_arbiter_pkg::*;
#(
    parameter int num_cce_p    = 4,
    parameter int msg_width_p  = 128,
    parameter int src_width_lp = safe_clog2(num_cce_p)
);
    logic [num_cce_p*msg_width_p-1:0] cce_cmd_i;
    logic [num_cce_p-1:0]             cce_cmd_v_i;
    logic [num_cce_p-1:0]             cce_cmd_ready_o;
    logic [msg_width_p-1:0]           mem_cmd_o;
    logic [src_width_lp-1:0]          mem_cmd_src_o;
    logic                             mem_cmd_v_o;
    logic                             mem_cmd_yumi_i;
    logic [msg_width_p-1:0]           mem_resp_i;
    logic [src_width_lp-1:0]          mem_resp_src_i;
    logic                             mem_resp_v_i;
    logic                             mem_resp_ready_o;
    logic [msg_width_p-1:0]           cce_resp_o;
    logic [num_cce_p-1:0]             cce_resp_v_o;
    logic [num_cce_p-1:0]             cce_resp_ready_i;

    // Arbiter side.
    modport slave (
        input  cce_cmd_i, cce_cmd_v_i, mem_cmd_yumi_i,
        input  mem_resp_i, mem_resp_src_i, mem_resp_v_i, cce_resp_ready_i,
        output cce_cmd_ready_o, mem_cmd_o, mem_cmd_src_o, mem_cmd_v_o,
        output mem_resp_ready_o, cce_resp_o, cce_resp_v_o
    );

    // CCEs plus memory, seen from outside the arbiter.
    modport master (
        output cce_cmd_i, cce_cmd_v_i, mem_cmd_yumi_i,
        output mem_resp_i, mem_resp_src_i, mem_resp_v_i, cce_resp_ready_i,
        input  cce_cmd_ready_o, mem_cmd_o, mem_cmd_src_o, mem_cmd_v_o,
        input  mem_resp_ready_o, cce_resp_o, cce_resp_v_o
    );
endinterface

// File: rtl/bp_cce_mem_arbiter_credit_counter.sv
// rtl/bp_cce_mem_arbiter_credit_counter.sv - per-CCE outstanding command credit counter
module bp_cce_mem_arbiter_credit_counter #(
    parameter int  max_outstanding_p = 8,
    localparam int count_width_lp    = $clog2(max_outstanding_p + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic at_max_o,
    output logic at_zero_o
);
    logic [count_width_lp-1:0] count_q;

    assign at_max_o  = (count_q == count_width_lp'(max_outstanding_p));
    assign at_zero_o = (count_q == '0);

    // Issue adds a credit in use, a returned response frees one; both together cancel.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (inc_i && !dec_i && !at_max_o) begin
            count_q <= count_q + count_width_lp'(1);
        end else if (dec_i && !inc_i && !at_zero_o) begin
            count_q <= count_q - count_width_lp'(1);
        end
    end
endmodule

// File: rtl/bp_cce_mem_arbiter.sv
// rtl/bp_cce_mem_arbiter.sv - round-robin CCE-Mem arbiter with credits; BP_CCE_MEM_ARBITER_PERF_EN adds perf counters
module bp_cce_mem_arbiter
    import bp_cce_mem_arbiter_pkg::*;
#(
    parameter int  num_cce_p         = 4,
    parameter int  msg_width_p       = 128,
    parameter int  max_outstanding_p = 8,
    localparam int src_width_lp      = safe_clog2(num_cce_p)
) (
    input  logic clk_i,
    input  logic reset_i,
`ifdef BP_CCE_MEM_ARBITER_PERF_EN
    output logic [num_cce_p*perf_cnt_width_lp-1:0] perf_grant_cnt_o,
    output logic [num_cce_p*perf_cnt_width_lp-1:0] perf_stall_cnt_o,
`endif
    bp_cce_mem_arbiter_if.slave bus
);
    typedef struct packed {
        logic [src_width_lp-1:0] src;
        logic [msg_width_p-1:0]  msg;
    } hold_entry_t;

    hold_state_e             state_q, state_n;
    hold_entry_t             hold_q, hold_n;
    logic [src_width_lp-1:0] rr_q, rr_n;
    logic [src_width_lp-1:0] winner, cand;
    logic [msg_width_p-1:0]  sel_msg;
    logic [num_cce_p-1:0]    eligible, grant_oh, resp_oh, resp_dec, at_max, at_zero;
    logic                    grant_any, can_load, load, resp_src_ok;

    assign eligible = bus.cce_cmd_v_i & ~at_max;
    assign can_load = (state_q == HOLD_EMPTY) || bus.mem_cmd_yumi_i;
    assign load     = can_load && grant_any && !reset_i;

    // Round-robin search starting at the pointer; first eligible CCE wins.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int k = 0; k < num_cce_p; k++) begin
            cand = src_width_lp'((int'(rr_q) + k) % num_cce_p);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                winner    = cand;
            end
        end
    end

    // One-hot ready to the winner only when the slot can take a command.
    always_comb begin
        grant_oh = '0;
        if (load) begin
            grant_oh[winner] = 1'b1;
        end
    end

    // Select the winning CCE's message from the flattened command bus.
    always_comb begin
        sel_msg = '0;
        for (int i = 0; i < num_cce_p; i++) begin
            if (winner == src_width_lp'(i)) begin
                sel_msg = bus.cce_cmd_i[i*msg_width_p +: msg_width_p];
            end
        end
    end

    // Slot occupancy, loaded entry and pointer advance for the next cycle.
    always_comb begin
        state_n = state_q;
        hold_n  = hold_q;
        rr_n    = rr_q;
        if (load) begin
            state_n    = HOLD_FULL;
            hold_n.src = winner;
            hold_n.msg = sel_msg;
            rr_n       = (winner == src_width_lp'(num_cce_p - 1)) ? '0 : winner + src_width_lp'(1);
        end else if (bus.mem_cmd_yumi_i) begin
            state_n = HOLD_EMPTY;
        end
    end

    // Slot and pointer registers; reset drops any held command.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= HOLD_EMPTY;
            hold_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_n;
            hold_q  <= hold_n;
            rr_q    <= rr_n;
        end
    end

    assign bus.cce_cmd_ready_o = grant_oh;
    assign bus.mem_cmd_v_o     = (state_q == HOLD_FULL);
    assign bus.mem_cmd_o       = hold_q.msg;
    assign bus.mem_cmd_src_o   = hold_q.src;

    assign resp_src_ok          = int'(bus.mem_resp_src_i) < num_cce_p;
    assign bus.mem_resp_ready_o = resp_src_ok && bus.cce_resp_ready_i[bus.mem_resp_src_i];
    assign bus.cce_resp_o       = bus.mem_resp_i;
    assign bus.cce_resp_v_o     = resp_oh;
    assign resp_dec             = resp_oh & {num_cce_p{bus.mem_resp_ready_o}};

    // Steer response valid to the CCE named by the echoed source id.
    always_comb begin
        resp_oh = '0;
        if (bus.mem_resp_v_i && resp_src_ok) begin
            resp_oh[bus.mem_resp_src_i] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < num_cce_p; gi++) begin : g_credit
        bp_cce_mem_arbiter_credit_counter #(
            .max_outstanding_p(max_outstanding_p)
        ) u_credit (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .inc_i    (grant_oh[gi]),
            .dec_i    (resp_dec[gi]),
            .at_max_o (at_max[gi]),
            .at_zero_o(at_zero[gi])
        );
    end

    // Protocol checks: no yumi on an empty slot, no stray source id, no credit underflow.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(bus.mem_cmd_yumi_i && state_q == HOLD_EMPTY));
            assert (!(bus.mem_resp_v_i && !resp_src_ok));
            assert ((resp_dec & ~grant_oh & at_zero) == '0);
        end
    end

`ifdef BP_CCE_MEM_ARBITER_PERF_EN
    for (genvar gi = 0; gi < num_cce_p; gi++) begin : g_perf
        logic [perf_cnt_width_lp-1:0] grant_cnt_q, stall_cnt_q;

        // Saturating counts of grants and of cycles spent waiting while valid.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                grant_cnt_q <= '0;
                stall_cnt_q <= '0;
            end else begin
                if (grant_oh[gi] && grant_cnt_q != '1) begin
                    grant_cnt_q <= grant_cnt_q + perf_cnt_width_lp'(1);
                end
                if (bus.cce_cmd_v_i[gi] && !grant_oh[gi] && stall_cnt_q != '1) begin
                    stall_cnt_q <= stall_cnt_q + perf_cnt_width_lp'(1);
                end
            end
        end

        assign perf_grant_cnt_o[gi*perf_cnt_width_lp +: perf_cnt_width_lp] = grant_cnt_q;
        assign perf_stall_cnt_o[gi*perf_cnt_width_lp +: perf_cnt_width_lp] = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_bp_cce_mem_arbiter.sv
// tb/tb_bp_cce_mem_arbiter.sv - directed scoreboard bench for bp_cce_mem_arbiter
module tb_bp_cce_mem_arbiter;
    localparam int N  = 4;
    localparam int MW = 128;

    typedef struct packed {
        logic [1:0]    src;
        logic [MW-1:0] msg;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_ready;
    int   total = 0;
    int   bad = 0;
    int   seq [N];
    sb_t  sb_q [$];
    logic [MW-1:0] held;
    logic [MW-1:0] resp_word;

    always #5 clk = ~clk;

    bp_cce_mem_arbiter_if #(.num_cce_p(N), .msg_width_p(MW)) bus ();

    assign bus.mem_cmd_yumi_i = bus.mem_cmd_v_o & mem_ready;

`ifdef BP_CCE_MEM_ARBITER_PERF_EN
    logic [N*32-1:0] perf_grant, perf_stall;
`endif

    bp_cce_mem_arbiter #(
        .num_cce_p(N),
        .msg_width_p(MW),
        .max_outstanding_p(8)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
`ifdef BP_CCE_MEM_ARBITER_PERF_EN
        .perf_grant_cnt_o(perf_grant),
        .perf_stall_cnt_o(perf_stall),
`endif
        .bus(bus)
    );

    function automatic logic [MW-1:0] payload(input int i, input int s);
        return {32'hCAFE0000 + 32'(i), 32'h5A5A5A5A, 32'(i), 32'(s)};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input int s);
        sb_t e;
        e.src = 2'(i);
        e.msg = payload(i, s);
        sb_q.push_back(e);
    endtask

    task automatic drive_payloads();
        for (int i = 0; i < N; i++) bus.cce_cmd_i[i*MW +: MW] = payload(i, seq[i]);
    endtask

    // Called mid-cycle: retire memory handshakes against the scoreboard, advance sources, step one clock.
    task automatic adv();
        sb_t e;
        if (bus.mem_cmd_v_o && bus.mem_cmd_yumi_i) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_underflow observed=%0h expected=none", {bus.mem_cmd_src_o, bus.mem_cmd_o});
            end else begin
                e = sb_q.pop_front();
                chk("mem_cmd", 160'({bus.mem_cmd_src_o, bus.mem_cmd_o}), 160'(e));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.cce_cmd_v_i[i] && bus.cce_cmd_ready_o[i]) seq[i]++;
        end
        @(posedge clk);
        #1;
        drive_payloads();
    endtask

    initial begin
        mem_ready            = 1'b0;
        bus.cce_cmd_v_i      = '0;
        bus.mem_resp_i       = '0;
        bus.mem_resp_src_i   = '0;
        bus.mem_resp_v_i     = 1'b0;
        bus.cce_resp_ready_i = '0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        drive_payloads();
        resp_word = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        // Reset state with every CCE requesting.
        bus.cce_cmd_v_i = 4'hF;
        @(posedge clk);
        #1;
        chk("rst_cmd_v", 160'(bus.mem_cmd_v_o), 160'(1'b0));
        chk("rst_ready", 160'(bus.cce_cmd_ready_o), 160'(4'b0000));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: all four requesting, memory always accepting -> 0,1,2,3,0.
        mem_ready = 1'b1;
        push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(0, 1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t1_ready", 160'(bus.cce_cmd_ready_o), 160'(4'b0001 << (k % 4)));
            adv();
        end
        bus.cce_cmd_v_i = '0;
        #1;
        chk("t1_idle_ready", 160'(bus.cce_cmd_ready_o), 160'(4'b0000));
        adv();

        // Response routing: blocked when the target FIFO is full, then accepted (CCE1 credit back to 0).
        bus.mem_resp_i       = resp_word;
        bus.mem_resp_src_i   = 2'd1;
        bus.mem_resp_v_i     = 1'b1;
        bus.cce_resp_ready_i = 4'b1101;
        #1;
        chk("resp_blocked_ready", 160'(bus.mem_resp_ready_o), 160'(1'b0));
        chk("resp_blocked_v", 160'(bus.cce_resp_v_o), 160'(4'b0010));
        adv();
        bus.cce_resp_ready_i = 4'hF;
        #1;
        chk("resp_ready", 160'(bus.mem_resp_ready_o), 160'(1'b1));
        chk("resp_v", 160'(bus.cce_resp_v_o), 160'(4'b0010));
        chk("resp_data", 160'(bus.cce_resp_o), 160'(resp_word));
        adv();
        bus.mem_resp_v_i = 1'b0;

        // 2: CCE1 alone, no responses -> 8 issued, then held off.
        bus.cce_cmd_v_i = 4'b0010;
        for (int k = 0; k < 8; k++) push(1, seq[1] + k);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_ready", 160'(bus.cce_cmd_ready_o), 160'(4'b0010));
            adv();
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_blocked", 160'(bus.cce_cmd_ready_o), 160'(4'b0000));
            adv();
        end

        // 3: one response to CCE1 frees exactly one more grant, on the following cycle.
        bus.mem_resp_src_i = 2'd1;
        bus.mem_resp_v_i   = 1'b1;
        push(1, seq[1]);
        #1;
        chk("t3_same_cycle", 160'(bus.cce_cmd_ready_o), 160'(4'b0000));
        chk("t3_resp_ready", 160'(bus.mem_resp_ready_o), 160'(1'b1));
        adv();
        bus.mem_resp_v_i = 1'b0;
        #1;
        chk("t3_regrant", 160'(bus.cce_cmd_ready_o), 160'(4'b0010));
        adv();
        #1;
        chk("t3_blocked_again", 160'(bus.cce_cmd_ready_o), 160'(4'b0000));
        adv();
        bus.cce_cmd_v_i = '0;

        // 4: CCE2 at 3 credits, simultaneous issue and return leaves 3 -> exactly 5 more grants.
        bus.cce_cmd_v_i = 4'b0100;
        for (int k = 0; k < 8; k++) push(2, seq[2] + k);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t4_pre", 160'(bus.cce_cmd_ready_o), 160'(4'b0100));
            adv();
        end
        bus.mem_resp_src_i = 2'd2;
        bus.mem_resp_v_i   = 1'b1;
        #1;
        chk("t4_both_ready", 160'(bus.cce_cmd_ready_o), 160'(4'b0100));
        chk("t4_both_resp_ready", 160'(bus.mem_resp_ready_o), 160'(1'b1));
        adv();
        bus.mem_resp_v_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("t4_after", 160'(bus.cce_cmd_ready_o), 160'((k < 5) ? 4'b0100 : 4'b0000));
            adv();
        end
        bus.cce_cmd_v_i = '0;

        // 5: memory stalls 5 cycles -> held command stable, no readies; release grants CCE3.
        bus.cce_cmd_v_i = 4'b0001;
        mem_ready = 1'b0;
        held = payload(0, seq[0]);
        push(0, seq[0]);
        #1;
        chk("t5_grant", 160'(bus.cce_cmd_ready_o), 160'(4'b0001));
        adv();
        bus.cce_cmd_v_i = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t5_v", 160'(bus.mem_cmd_v_o), 160'(1'b1));
            chk("t5_cmd", 160'({bus.mem_cmd_src_o, bus.mem_cmd_o}), 160'({2'd0, held}));
            chk("t5_ready", 160'(bus.cce_cmd_ready_o), 160'(4'b0000));
            adv();
        end
        mem_ready = 1'b1;
        push(3, seq[3]);
        #1;
        chk("t5_release_ready", 160'(bus.cce_cmd_ready_o), 160'(4'b1000));
        adv();
        bus.cce_cmd_v_i = '0;
        #1;
        adv();

        // 6: CCE3 to 5 credits with one command held, then async reset mid-cycle.
        bus.cce_cmd_v_i = 4'b1000;
        for (int k = 0; k < 3; k++) push(3, seq[3] + k);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t6_fill", 160'(bus.cce_cmd_ready_o), 160'(4'b1000));
            adv();
        end
        bus.cce_cmd_v_i = '0;
        mem_ready = 1'b0;
        #1;
        chk("t6_held", 160'(bus.mem_cmd_v_o), 160'(1'b1));
        bus.cce_cmd_v_i = 4'b1001;
        rst = 1'b1;
        #1;
        chk("t6_async_v", 160'(bus.mem_cmd_v_o), 160'(1'b0));
        chk("t6_async_ready", 160'(bus.cce_cmd_ready_o), 160'(4'b0000));
        sb_q.delete();
        adv();
        rst = 1'b0;
        mem_ready = 1'b1;
        // Cleared credits and pointer: CCE0 and CCE3 alternate, 8 grants each, then stop.
        for (int k = 0; k < 8; k++) begin
            push(0, seq[0] + k);
            push(3, seq[3] + k);
        end
        for (int k = 0; k < 18; k++) begin
            #1;
            chk("t6_post_ready", 160'(bus.cce_cmd_ready_o),
                160'((k < 16) ? ((k % 2 == 0) ? 4'b0001 : 4'b1000) : 4'b0000));
            adv();
        end
        bus.cce_cmd_v_i = '0;
        #1;
        chk("sb_empty", 160'(sb_q.size()), 160'(0));
        chk("final_v", 160'(bus.mem_cmd_v_o), 160'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
